// File: rtl/audio_adc_rx.sv
// audio_adc_rx: serial audio receiver for the codec ADC path.
//
// Oversamples the codec bit clock, LR clock and ADC data in the 18.432 MHz domain.
// Deserializes left-justified, MSB-first stereo frames and presents each complete
// left/right pair as parallel samples with a valid/ack handshake.
//
// Ports:
//   CLK_18_4      in   system clock, all logic on its rising edge
//   RST_N         in   asynchronous active-low reset
//   AUD_BCK       in   codec bit clock (asynchronous)
//   AUD_ADCLRCK   in   codec LR clock, low = left, high = right (asynchronous)
//   AUD_ADCDAT    in   serial ADC data, valid at BCK rising edges (asynchronous)
//   sample_ack    in   consumer acknowledge of the held pair
//   left_sample   out  last complete left sample (two's complement)
//   right_sample  out  last complete right sample (two's complement)
//   sample_valid  out  high while an unacknowledged pair is held
//   overrun       out  one-cycle pulse when a new pair overwrites an unacknowledged one
//   frame_err     out  one-cycle pulse when a channel ends with too few bits
module audio_adc_rx #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  CLK_18_4,
    input  logic                  RST_N,
    input  logic                  AUD_BCK,
    input  logic                  AUD_ADCLRCK,
    input  logic                  AUD_ADCDAT,
    input  logic                  sample_ack,
    output logic [DATA_WIDTH-1:0] left_sample,
    output logic [DATA_WIDTH-1:0] right_sample,
    output logic                  sample_valid,
    output logic                  overrun,
    output logic                  frame_err
);

    localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        StAlign,
        StShift,
        StHold
    } state_e;

    // Synchronizers; s3 exists only on BCK and LRCK for edge detection.
    logic bck_s1_q, bck_s2_q, bck_s3_q;
    logic lr_s1_q, lr_s2_q, lr_s3_q;
    logic dat_s1_q, dat_s2_q;

    logic bck_rise;
    logic lr_edge;

    state_e                state_q, state_d;
    logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  chan_q, chan_d;
    logic [DATA_WIDTH-1:0] left_hold_q, left_hold_d;
    logic                  left_ok_q, left_ok_d;
    logic [DATA_WIDTH-1:0] left_sample_q, left_sample_d;
    logic [DATA_WIDTH-1:0] right_sample_q, right_sample_d;
    logic                  sample_valid_q, sample_valid_d;
    logic                  overrun_q, overrun_d;
    logic                  frame_err_q, frame_err_d;

    // Working values after any LRCK edge has been applied in this cycle.
    logic                  capture;
    logic [CntW-1:0]       cnt_v;
    logic                  chan_v;
    logic [DATA_WIDTH-1:0] shift_v;

    always_ff @(posedge CLK_18_4 or negedge RST_N) begin
        if (!RST_N) begin
            bck_s1_q <= 1'b0;
            bck_s2_q <= 1'b0;
            bck_s3_q <= 1'b0;
            lr_s1_q  <= 1'b0;
            lr_s2_q  <= 1'b0;
            lr_s3_q  <= 1'b0;
            dat_s1_q <= 1'b0;
            dat_s2_q <= 1'b0;
        end else begin
            bck_s1_q <= AUD_BCK;
            bck_s2_q <= bck_s1_q;
            bck_s3_q <= bck_s2_q;
            lr_s1_q  <= AUD_ADCLRCK;
            lr_s2_q  <= lr_s1_q;
            lr_s3_q  <= lr_s2_q;
            dat_s1_q <= AUD_ADCDAT;
            dat_s2_q <= dat_s1_q;
        end
    end

    assign bck_rise = bck_s2_q & ~bck_s3_q;
    assign lr_edge  = lr_s2_q ^ lr_s3_q;

    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        shift_d        = shift_q;
        chan_d         = chan_q;
        left_hold_d    = left_hold_q;
        left_ok_d      = left_ok_q;
        left_sample_d  = left_sample_q;
        right_sample_d = right_sample_q;
        sample_valid_d = sample_valid_q;
        overrun_d      = 1'b0;
        frame_err_d    = 1'b0;
        capture        = 1'b0;
        cnt_v          = bit_cnt_q;
        chan_v         = chan_q;
        shift_v        = {shift_q[DATA_WIDTH-2:0], dat_s2_q};

        if (sample_ack && sample_valid_q) begin
            sample_valid_d = 1'b0;
        end

        // An LRCK edge always restarts a channel; a coincident BCK rise then
        // becomes the MSB of the new channel.
        if (lr_edge) begin
            if (state_q == StShift) begin
                frame_err_d = 1'b1;
            end
            if (!lr_s2_q) begin
                left_ok_d = 1'b0;
            end
            cnt_v     = '0;
            chan_v    = lr_s2_q;
            chan_d    = lr_s2_q;
            bit_cnt_d = '0;
            state_d   = StShift;
            capture   = bck_rise;
        end else if (state_q == StShift) begin
            capture = bck_rise;
        end

        if (capture) begin
            shift_d   = shift_v;
            bit_cnt_d = cnt_v + CntW'(1);
            if (cnt_v == LastCnt) begin
                state_d = StHold;
                if (!chan_v) begin
                    left_hold_d = shift_v;
                    left_ok_d   = 1'b1;
                end else if (left_ok_q) begin
                    left_sample_d  = left_hold_q;
                    right_sample_d = shift_v;
                    sample_valid_d = 1'b1;
                    left_ok_d      = 1'b0;
                    overrun_d      = sample_valid_q & ~sample_ack;
                end
                // A right channel with no preceding complete left is dropped silently.
            end
        end
    end

    always_ff @(posedge CLK_18_4 or negedge RST_N) begin
        if (!RST_N) begin
            state_q        <= StAlign;
            bit_cnt_q      <= '0;
            shift_q        <= '0;
            chan_q         <= 1'b0;
            left_hold_q    <= '0;
            left_ok_q      <= 1'b0;
            left_sample_q  <= '0;
            right_sample_q <= '0;
            sample_valid_q <= 1'b0;
            overrun_q      <= 1'b0;
            frame_err_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            chan_q         <= chan_d;
            left_hold_q    <= left_hold_d;
            left_ok_q      <= left_ok_d;
            left_sample_q  <= left_sample_d;
            right_sample_q <= right_sample_d;
            sample_valid_q <= sample_valid_d;
            overrun_q      <= overrun_d;
            frame_err_q    <= frame_err_d;
        end
    end

    assign left_sample  = left_sample_q;
    assign right_sample = right_sample_q;
    assign sample_valid = sample_valid_q;
    assign overrun      = overrun_q;
    assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_audio_adc_rx.sv
// Bench for audio_adc_rx: a codec model drives directed frames, pushing each
// expected pair (with its load cycle and overrun flag) into a queue; a monitor
// pops and compares whenever the DUT presents a new pair.
module tb_audio_adc_rx;

    localparam int unsigned W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic bck_pin = 1'b0;
    logic lr_pin = 1'b0;
    logic dat_pin = 1'b0;
    logic ack_man = 1'b0;
    logic ack_auto = 1'b0;
    logic auto_en = 1'b0;
    logic sample_ack;
    logic [W-1:0] left_sample;
    logic [W-1:0] right_sample;
    logic sample_valid;
    logic overrun;
    logic frame_err;

    assign sample_ack = ack_man | ack_auto;

    audio_adc_rx #(
        .DATA_WIDTH(W)
    ) dut (
        .CLK_18_4    (clk),
        .RST_N       (rst_n),
        .AUD_BCK     (bck_pin),
        .AUD_ADCLRCK (lr_pin),
        .AUD_ADCDAT  (dat_pin),
        .sample_ack  (sample_ack),
        .left_sample (left_sample),
        .right_sample(right_sample),
        .sample_valid(sample_valid),
        .overrun     (overrun),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] l;
        logic [W-1:0] r;
        logic         ov;
        int           cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ov_cnt = 0;
    int fe_cnt = 0;
    int ov_b;
    int fe_b;
    logic valid_prev = 1'b0;
    logic ov_prev = 1'b0;
    logic fe_prev = 1'b0;
    logic [W-1:0] l_prev = '0;
    logic [W-1:0] r_prev = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Consumer that acknowledges each pair one cycle after it appears.
    always @(negedge clk) ack_auto <= auto_en && sample_valid && !ack_auto;

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (overrun) begin
                ov_cnt++;
                check("overrun_width", ov_prev, 0);
            end
            if (frame_err) begin
                fe_cnt++;
                check("frame_err_width", fe_prev, 0);
            end
            if (sample_valid && (!valid_prev || overrun || left_sample !== l_prev ||
                                 right_sample !== r_prev)) begin
                check("load_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    check("left_sample", left_sample, mon_e.l);
                    check("right_sample", right_sample, mon_e.r);
                    check("overrun_at_load", overrun, mon_e.ov);
                    check("load_cycle", cyc, mon_e.cyc);
                end
            end
        end
        valid_prev <= sample_valid;
        ov_prev    <= overrun;
        fe_prev    <= frame_err;
        l_prev     <= left_sample;
        r_prev     <= right_sample;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        check({tag, "_left"}, left_sample, 0);
        check({tag, "_right"}, right_sample, 0);
        check({tag, "_valid"}, sample_valid, 0);
        check({tag, "_overrun"}, overrun, 0);
        check({tag, "_frame_err"}, frame_err, 0);
    endtask

    // One channel: nbits data bits MSB first then npad zero bits; data and LRCK
    // change on BCK falls unless lr_late moves LRCK onto the first BCK rise.
    task automatic send_chan(input logic lr, input logic [W-1:0] w, input int nbits,
                             input int npad, input int half, input bit lr_late,
                             input bit push, input logic [W-1:0] exp_l, input bit exp_ov,
                             input bit ack_at_load);
        exp_t e;
        for (int i = 0; i < nbits + npad; i++) begin
            bck_pin = 1'b0;
            if (i < nbits) dat_pin = w[W-1-i];
            else dat_pin = 1'b0;
            if (i == 0 && !lr_late) lr_pin = lr;
            wait_clks(half);
            if (i == 0 && lr_late) lr_pin = lr;
            bck_pin = 1'b1;
            if (push && i == nbits - 1) begin
                e.l   = exp_l;
                e.r   = w;
                e.ov  = exp_ov;
                e.cyc = cyc + 3;
                exp_q.push_back(e);
            end
            if (ack_at_load && i == nbits - 1) begin
                wait_clks(2);
                ack_man = 1'b1;
                wait_clks(1);
                ack_man = 1'b0;
                wait_clks(half - 3);
            end else begin
                wait_clks(half);
            end
        end
    endtask

    task automatic send_frame(input logic [W-1:0] l, input logic [W-1:0] r, input int npad,
                              input int half, input bit lr_late, input bit push,
                              input bit exp_ov, input bit ack_at_load);
        send_chan(1'b0, l, W, npad, half, lr_late, 1'b0, '0, 1'b0, 1'b0);
        send_chan(1'b1, r, W, npad, half, lr_late, push, l, exp_ov, ack_at_load);
    endtask

    initial begin
        // Reset state.
        wait_clks(3);
        chk_zero("reset");

        // Alignment: reset released in the middle of a right channel.
        send_chan(1'b1, 16'hF0F0, 6, 0, 6, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        rst_n = 1'b1;
        send_chan(1'b1, 16'hFFFF, 10, 0, 6, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        auto_en = 1'b1;

        // Nominal frames with pad bits.
        send_frame(16'hA5C3, 16'h1234, 16, 6, 1'b0, 1'b1, 1'b0, 1'b0);
        ov_b = ov_cnt;
        fe_b = fe_cnt;
        send_frame(16'hA5C3, 16'h1234, 16, 6, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_clks(4);
        check("nom_left", left_sample, 16'hA5C3);
        check("nom_right", right_sample, 16'h1234);
        check("nom_acked", sample_valid, 0);

        // LRCK edge coincident with the first BCK rise of each channel.
        send_frame(16'h5A5A, 16'hC3A5, 0, 6, 1'b1, 1'b1, 1'b0, 1'b0);
        wait_clks(4);
        check("nom_overrun_cnt", ov_cnt - ov_b, 0);
        check("nom_frame_err_cnt", fe_cnt - fe_b, 0);

        // Short left channel.
        fe_b = fe_cnt;
        send_chan(1'b0, 16'hDEAD, 10, 0, 6, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        send_chan(1'b1, 16'hBEEF, 16, 0, 6, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        send_frame(16'h6C3E, 16'h91B7, 0, 6, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_clks(4);
        check("short_frame_err_cnt", fe_cnt - fe_b, 1);
        check("short_next_left", left_sample, 16'h6C3E);

        // Handshake: no ack for two frames, then ack coincident with a load.
        auto_en = 1'b0;
        wait_clks(2);
        check("hs_idle_valid", sample_valid, 0);
        ov_b = ov_cnt;
        send_frame(16'h8000, 16'h7FFF, 16, 6, 1'b0, 1'b1, 1'b0, 1'b0);
        send_frame(16'h0001, 16'hFFFF, 16, 6, 1'b0, 1'b1, 1'b1, 1'b0);
        wait_clks(4);
        check("hs_valid_held", sample_valid, 1);
        check("hs_left", left_sample, 16'h0001);
        check("hs_right", right_sample, 16'hFFFF);
        check("hs_overrun_cnt", ov_cnt - ov_b, 1);
        send_frame(16'h1357, 16'h2468, 0, 6, 1'b0, 1'b1, 1'b0, 1'b1);
        wait_clks(4);
        check("hs_ack_load_valid", sample_valid, 1);
        check("hs_ack_load_ov_cnt", ov_cnt - ov_b, 1);
        ack_man = 1'b1;
        wait_clks(1);
        ack_man = 1'b0;
        wait_clks(1);
        check("hs_acked", sample_valid, 0);
        ack_man = 1'b1;
        wait_clks(3);
        ack_man = 1'b0;
        wait_clks(1);
        check("hs_idle_ack", sample_valid, 0);

        // Reset during right bit 8 while a pair is held.
        send_frame(16'hBEEF, 16'hCAFE, 0, 6, 1'b0, 1'b1, 1'b0, 1'b0);
        send_chan(1'b0, 16'h1111, 16, 0, 6, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        send_chan(1'b1, 16'h2222, 7, 0, 6, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        check("pre_rst_valid", sample_valid, 1);
        bck_pin = 1'b0;
        dat_pin = 1'b0;
        wait_clks(2);
        rst_n = 1'b0;
        #1;
        chk_zero("rst_mid");
        wait_clks(4);
        rst_n = 1'b1;
        bck_pin = 1'b1;
        wait_clks(6);
        send_chan(1'b1, 16'h00FF, 8, 0, 6, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        auto_en = 1'b1;
        send_frame(16'h0F0F, 16'hF0F0, 0, 6, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_clks(4);
        check("rst_resume_left", left_sample, 16'h0F0F);
        check("rst_resume_right", right_sample, 16'hF0F0);

        // Stress: fastest BCK, random data.
        ov_b = ov_cnt;
        fe_b = fe_cnt;
        for (int f = 0; f < 100; f++) begin
            send_frame(W'($urandom), W'($urandom), 0, 3, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        wait_clks(10);
        check("stress_overrun_cnt", ov_cnt - ov_b, 0);
        check("stress_frame_err_cnt", fe_cnt - fe_b, 0);
        check("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
